// File: rtl/cpu_clock_monitor_if.sv
// Bundle between the CPU clock monitor and the I/O logic using its strobes.
// master drives cpu_clk/clr_err and observes; slave is the monitor itself.
interface cpu_clock_monitor_if #(
   parameter int CNT_W = 16
);
   logic             cpu_clk;
   logic             clr_err;
   logic             rise_pulse;
   logic             fall_pulse;
   logic [CNT_W-1:0] half_period;
   logic             locked;
   logic             lost;
   logic [7:0]       err_count;

   modport master (
      output cpu_clk,
      output clr_err,
      input  rise_pulse,
      input  fall_pulse,
      input  half_period,
      input  locked,
      input  lost,
      input  err_count
   );

   modport slave (
      input  cpu_clk,
      input  clr_err,
      output rise_pulse,
      output fall_pulse,
      output half_period,
      output locked,
      output lost,
      output err_count
   );
endinterface

// File: rtl/cpu_clock_monitor.sv
// Fast-domain observer of the divided CPU clock: edge strobes, half-period
// measurement, lock/loss status. CPU_CLOCK_MONITOR_ERRCNT_EN adds err_count.
module cpu_clock_monitor #(
   parameter int EXPECTED   = 51,
   parameter int TOLERANCE  = 2,
   parameter int LOCK_COUNT = 4,
   parameter int TIMEOUT    = 255,
   parameter int CNT_W      = 16
) (
   input logic clk,
   input logic rst,
   cpu_clock_monitor_if.slave mon
);

   localparam int GOOD_W = $clog2(LOCK_COUNT + 1);

   localparam logic [CNT_W-1:0] LO_LIM  = CNT_W'(EXPECTED - TOLERANCE);
   localparam logic [CNT_W-1:0] HI_LIM  = CNT_W'(EXPECTED + TOLERANCE);
   localparam logic [CNT_W-1:0] TMO     = CNT_W'(TIMEOUT);
   localparam logic [CNT_W-1:0] TMO_M1  = CNT_W'(TIMEOUT - 1);
   localparam logic [GOOD_W-1:0] LCK_N  = GOOD_W'(LOCK_COUNT);

   typedef enum logic [1:0] {
      IDLE,
      ACQUIRE,
      LOCKED,
      LOST
   } state_t;

   logic              s1_q, s2_q, s3_q;
   logic              rise_q, fall_q;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [CNT_W-1:0]  hp_q, hp_d;
   logic [GOOD_W-1:0] good_q, good_d;
   logic [GOOD_W-1:0] good_inc;
   state_t            state_q, state_d;
   logic              lost_q, lost_d;

   logic edge_w;
   logic rise_w;
   logic fall_w;
   logic in_tol;
   logic timeout_w;
   logic loss_w;

   assign edge_w = s2_q ^ s3_q;
   assign rise_w = s2_q & ~s3_q;
   assign fall_w = ~s2_q & s3_q;

   assign in_tol   = (cnt_q >= LO_LIM) && (cnt_q <= HI_LIM);
   assign good_inc = good_q + GOOD_W'(1);

   // The cycle the counter would step onto TIMEOUT; fires once per stall.
   assign timeout_w = !edge_w && (cnt_q == TMO_M1);

   // Two-flop synchroniser plus the edge-history flop.
   always_ff @(posedge clk) begin
      if (rst) begin
         s1_q <= 1'b0;
         s2_q <= 1'b0;
         s3_q <= 1'b0;
      end else begin
         s1_q <= mon.cpu_clk;
         s2_q <= s1_q;
         s3_q <= s2_q;
      end
   end

   // Registered edge strobes, aligned with the status update.
   always_ff @(posedge clk) begin
      if (rst) begin
         rise_q <= 1'b0;
         fall_q <= 1'b0;
      end else begin
         rise_q <= rise_w;
         fall_q <= fall_w;
      end
   end

   // Interval counter: restarts at 1 on an edge, saturates at TIMEOUT.
   always_comb begin
      cnt_d = cnt_q;
      if (edge_w) begin
         cnt_d = CNT_W'(1);
      end else if (cnt_q != TMO) begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   // Counter register.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   // Lock FSM next state, measurement capture and loss detection.
   always_comb begin
      state_d = state_q;
      good_d  = good_q;
      hp_d    = hp_q;
      loss_w  = 1'b0;
      unique case (state_q)
         IDLE: begin
            good_d = '0;
            if (edge_w) begin
               state_d = ACQUIRE;
            end
         end
         ACQUIRE: begin
            if (edge_w) begin
               hp_d = cnt_q;
               if (in_tol) begin
                  good_d = good_inc;
                  if (good_inc == LCK_N) begin
                     state_d = LOCKED;
                  end
               end else begin
                  good_d = '0;
               end
            end else if (timeout_w) begin
               state_d = IDLE;
               good_d  = '0;
            end
         end
         LOCKED: begin
            if (edge_w) begin
               hp_d = cnt_q;
               if (!in_tol) begin
                  loss_w = 1'b1;
               end
            end else if (timeout_w) begin
               loss_w = 1'b1;
            end
            if (loss_w) begin
               state_d = LOST;
               good_d  = '0;
            end
         end
         LOST: begin
            if (edge_w) begin
               hp_d    = cnt_q;
               state_d = ACQUIRE;
               good_d  = '0;
            end
         end
         default: begin
            state_d = IDLE;
            good_d  = '0;
         end
      endcase
   end

   // Sticky loss flag; a loss in the same cycle wins over the clear.
   always_comb begin
      lost_d = lost_q;
      if (mon.clr_err) begin
         lost_d = 1'b0;
      end
      if (loss_w) begin
         lost_d = 1'b1;
      end
   end

   // FSM, measurement and status registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         good_q  <= '0;
         hp_q    <= '0;
         lost_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         good_q  <= good_d;
         hp_q    <= hp_d;
         lost_q  <= lost_d;
      end
   end

`ifdef CPU_CLOCK_MONITOR_ERRCNT_EN
   logic [7:0] err_q, err_d;

   // Saturating loss counter; clear plus loss together leaves exactly 1.
   always_comb begin
      err_d = err_q;
      if (mon.clr_err) begin
         err_d = 8'd0;
      end
      if (loss_w) begin
         if (mon.clr_err) begin
            err_d = 8'd1;
         end else if (err_q != 8'hff) begin
            err_d = err_q + 8'd1;
         end
      end
   end

   // Loss counter register.
   always_ff @(posedge clk) begin
      if (rst) begin
         err_q <= 8'd0;
      end else begin
         err_q <= err_d;
      end
   end

   assign mon.err_count = err_q;
`else
   assign mon.err_count = 8'd0;
`endif

   assign mon.rise_pulse  = rise_q;
   assign mon.fall_pulse  = fall_q;
   assign mon.half_period = hp_q;
   assign mon.locked      = (state_q == LOCKED);
   assign mon.lost        = lost_q;

endmodule
